// File: rtl/tlul_lsu_host.sv
// tlul_lsu_host: core load/store port (req/gnt/rvalid) to TL-UL host adapter.
// Tracks up to MaxOutstanding transactions with a counter and rolling source
// tags; responses return to the core in order. The D-channel response to the
// core is combinational by default, or registered one cycle when the macro
// TLUL_HOST_RSP_REG_EN is defined.

package tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = 4;
    localparam int TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [7:0] rsvd;
    } tl_a_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module tlul_lsu_host #(
    parameter int MaxOutstanding = 2,
    parameter int SourceW        = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output tlul_pkg::tl_h2d_t tl_h_o,
    input  tlul_pkg::tl_d2h_t tl_h_i
);
    import tlul_pkg::*;

    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [CntW-1:0]    cnt_q;
    logic [SourceW-1:0] src_q;
    logic [SourceW-1:0] exp_q;

    logic        a_valid;
    logic        a_fire;
    logic        dv_fire;
    logic        src_err;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Fields the adapter never consumes; kept visible to avoid dangling inputs.
    logic unused_sigs;
    assign unused_sigs = ^{addr_i[1:0], tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink};

    // Issue is blocked in reset and whenever every slot is in use; a D fire
    // in the same cycle only frees a slot from the next cycle onward.
    assign a_valid = rst_ni & req_i & (cnt_q < CntW'(MaxOutstanding));
    assign a_fire  = a_valid & tl_h_i.a_ready;
    assign gnt_o   = a_fire;

    // d_ready is tied high, so d_valid alone is a D fire; beats with nothing
    // outstanding (e.g. answers to pre-reset requests) are dropped.
    assign dv_fire = tl_h_i.d_valid & (cnt_q != '0);
    assign src_err = tl_h_i.d_source != TL_AIW'(exp_q);

    // A-channel fields driven straight from the held core request.
    always_comb begin
        tl_h_o           = '0;
        tl_h_o.a_valid   = a_valid;
        tl_h_o.a_param   = 3'd0;
        tl_h_o.a_size    = TL_SZW'(2);
        tl_h_o.a_source  = TL_AIW'(src_q);
        tl_h_o.a_address = {addr_i[31:2], 2'b00};
        tl_h_o.a_mask    = we_i ? be_i : 4'hF;
        tl_h_o.a_data    = wdata_i;
        tl_h_o.a_user    = TL_A_USER_DEFAULT;
        tl_h_o.d_ready   = 1'b1;
        if (!we_i)             tl_h_o.a_opcode = Get;
        else if (be_i == 4'hF) tl_h_o.a_opcode = PutFullData;
        else                   tl_h_o.a_opcode = PutPartialData;
    end

    // Core response for the current valid D beat.
    always_comb begin
        rsp_valid = dv_fire;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (dv_fire) begin
            if (tl_h_i.d_opcode == AccessAckData) rsp_rdata = tl_h_i.d_data;
            rsp_err = tl_h_i.d_error | src_err;
        end
    end

`ifdef TLUL_HOST_RSP_REG_EN
    // Registered response: appears one cycle after the D fire.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= rsp_valid;
            rdata_o  <= rsp_rdata;
            err_o    <= rsp_err;
        end
    end
`else
    assign rvalid_o = rsp_valid;
    assign rdata_o  = rsp_rdata;
    assign err_o    = rsp_err;
`endif

    // Outstanding counter plus issue/expect tags, both wrapping at MaxOutstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            src_q <= '0;
            exp_q <= '0;
        end else begin
            case ({a_fire, dv_fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (a_fire)
                src_q <= (src_q == SourceW'(MaxOutstanding - 1)) ? '0 : src_q + 1'b1;
            if (dv_fire)
                exp_q <= (exp_q == SourceW'(MaxOutstanding - 1)) ? '0 : exp_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_tlul_lsu_host.sv
// Testbench for tlul_lsu_host: directed scenarios followed by random traffic,
// checked against a queue-based model of outstanding transactions.
module tb_tlul_lsu_host;
    import tlul_pkg::*;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, gnt, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;

    int checks   = 0;
    int failures = 0;

    // Model: tags of accepted-but-unanswered requests, oldest first.
    int          outq[$];
    int          issued;
    logic        last_gnt;
    logic        p_rv;
    logic [31:0] p_rd;
    logic        p_err;

    tlul_lsu_host #(.MaxOutstanding(MAX), .SourceW(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we),
        .be_i(be), .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .tl_h_o(tl_h), .tl_h_i(tl_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setreq(input logic r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic setd(input logic v, input tl_d_op_e op, input logic [31:0] d,
                        input int src, input logic e);
        tl_d.d_valid  = v;
        tl_d.d_opcode = op;
        tl_d.d_data   = d;
        tl_d.d_source = TL_AIW'(src);
        tl_d.d_error  = e;
    endtask

    function automatic int oldest();
        return (outq.size() > 0) ? outq[0] : 0;
    endfunction

    // One clock: check at negedge against the model, then advance the model.
    task automatic cyc(input string tag);
        logic ev, eg, vd, er;
        logic [31:0] rd;
        int eop;
        @(negedge clk);
        ev = rst_n && req && (outq.size() < MAX);
        eg = ev && tl_d.a_ready;
        chk({tag, ".a_valid"}, tl_h.a_valid, ev);
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".d_ready"}, tl_h.d_ready, 1'b1);
        if (ev) begin
            eop = !we ? 4 : (be == 4'hF) ? 0 : 1;
            chk({tag, ".a_opcode"}, tl_h.a_opcode, eop);
            chk({tag, ".a_address"}, tl_h.a_address, {addr[31:2], 2'b00});
            chk({tag, ".a_mask"}, tl_h.a_mask, we ? be : 4'hF);
            chk({tag, ".a_data"}, tl_h.a_data, wdata);
            chk({tag, ".a_source"}, tl_h.a_source, issued % MAX);
            chk({tag, ".a_size"}, tl_h.a_size, 2);
            chk({tag, ".a_param"}, tl_h.a_param, 0);
        end
        vd = rst_n && tl_d.d_valid && (outq.size() > 0);
        rd = (vd && tl_d.d_opcode == AccessAckData) ? tl_d.d_data : 32'h0;
        er = vd && (tl_d.d_error || int'(tl_d.d_source) != oldest());
`ifdef TLUL_HOST_RSP_REG_EN
        chk({tag, ".rvalid"}, rvalid, p_rv);
        chk({tag, ".rdata"}, rdata, p_rd);
        chk({tag, ".err"}, err, p_err);
        p_rv = vd; p_rd = rd; p_err = er;
`else
        chk({tag, ".rvalid"}, rvalid, vd);
        chk({tag, ".rdata"}, rdata, rd);
        chk({tag, ".err"}, err, er);
`endif
        if (eg) begin
            outq.push_back(issued % MAX);
            issued++;
        end
        if (vd) void'(outq.pop_front());
        last_gnt = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        outq.delete();
        issued = 0; last_gnt = 1'b0;
        p_rv = 1'b0; p_rd = '0; p_err = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, ".gnt"}, gnt, 1'b0);
        chk({tag, ".a_valid"}, tl_h.a_valid, 1'b0);
        chk({tag, ".d_ready"}, tl_h.d_ready, 1'b1);
        chk({tag, ".rvalid"}, rvalid, 1'b0);
        chk({tag, ".rdata"}, rdata, 32'h0);
        chk({tag, ".err"}, err, 1'b0);
    endtask

    initial begin
        tl_d = '0;
        tl_d.a_ready = 1'b1;
        setreq(1, 0, 4'hF, 32'h0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #3;
        reset_outputs("reset");
        setreq(0, 0, 4'hF, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load of an unaligned address, answered with AccessAckData.
        setreq(1, 0, 4'h3, 32'h0000_1006, 32'h0);
        cyc("load_a");
        setreq(0, 0, 4'h0, 32'h0, 32'h0);
        setd(1, AccessAckData, 32'hDEAD_BEEF, oldest(), 0);
        cyc("load_d");
        setd(0, AccessAck, 32'h0, 0, 0);
        cyc("load_idle");

        // Single-byte store, AccessAck must return zero data.
        setreq(1, 1, 4'b0100, 32'h0000_2000, 32'h00AB_0000);
        cyc("bstore_a");
        setreq(0, 0, 4'h0, 32'h0, 32'h0);
        setd(1, AccessAck, 32'h1234_5678, oldest(), 0);
        cyc("bstore_d");
        setd(0, AccessAck, 32'h0, 0, 0);
        cyc("bstore_idle");

        // a_ready low: request held, no grant, fields stable.
        setreq(1, 1, 4'hF, 32'h0000_3008, 32'h5555_AAAA);
        tl_d.a_ready = 1'b0;
        cyc("bp0");
        cyc("bp1");
        tl_d.a_ready = 1'b1;
        cyc("bp_gnt");

        // Fill to MaxOutstanding, then stall until a D beat frees a slot.
        setreq(1, 0, 4'hF, 32'h0000_4000, 32'h0);
        cyc("full_a1");
        setreq(1, 0, 4'hF, 32'h0000_4004, 32'h0);
        cyc("full_stall0");
        cyc("full_stall1");
        setd(1, AccessAckData, 32'h1111_0000, oldest(), 0);
        cyc("full_dfree");
        setd(1, AccessAckData, 32'h2222_0000, oldest(), 0);
        cyc("simul_ad");
        setreq(0, 0, 4'h0, 32'h0, 32'h0);
        setd(1, AccessAckData, 32'h3333_0000, oldest() ^ 1, 0);
        cyc("bad_src");
        setd(0, AccessAck, 32'h0, 0, 0);
        cyc("drain_idle");

        // Load answered with d_error.
        setreq(1, 0, 4'hF, 32'h0000_5000, 32'h0);
        cyc("derr_a");
        setreq(0, 0, 4'h0, 32'h0, 32'h0);
        setd(1, AccessAckData, 32'h4444_4444, oldest(), 1);
        cyc("derr_d");

        // Spurious beat with nothing outstanding.
        setd(1, AccessAckData, 32'h9999_9999, 0, 0);
        cyc("spurious");
        setd(0, AccessAck, 32'h0, 0, 0);
        cyc("spur_idle");

        // Reset while a load is outstanding; its late answer must be dropped.
        setreq(1, 0, 4'hF, 32'h0000_6000, 32'h0);
        cyc("rst_a");
        setd(1, AccessAckData, 32'hCAFE_F00D, oldest(), 0);
        rst_n = 1'b0;
        #1;
        reset_outputs("rst_mid");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        setreq(0, 0, 4'h0, 32'h0, 32'h0);
        cyc("late_beat");
        setd(0, AccessAck, 32'h0, 0, 0);
        cyc("post_rst");

        // Random traffic; a pending request keeps its attributes until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(req && !last_gnt))
                setreq(($urandom % 4) != 0, $urandom % 2, 4'($urandom),
                       $urandom, $urandom);
            tl_d.a_ready = ($urandom % 4) != 0;
            setd(($urandom % 3) == 0,
                 ($urandom % 2) ? AccessAckData : AccessAck,
                 $urandom,
                 (outq.size() > 0 && ($urandom % 8) != 0) ? oldest() : int'($urandom % 4),
                 ($urandom % 8) == 0);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
